// File: rtl/ewma_pkg.sv
// rtl/ewma_pkg.sv - shared types and constants for the multi-channel EWMA filter
package ewma_pkg;

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    localparam int ALPHA_W_DEF = 8;

    // Half an LSB of the alpha fraction, added before the arithmetic shift.
    function automatic int round_const(input int alpha_w);
        return (alpha_w > 0) ? (1 << (alpha_w - 1)) : 0;
    endfunction

endpackage

// File: rtl/ewma_filter_mc_if.sv
// rtl/ewma_filter_mc_if.sv - sample-in / average-out handshake bundle
interface ewma_filter_mc_if
    import ewma_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int CH_W    = 2,
    parameter int ALPHA_W = ALPHA_W_DEF
);
    logic               in_valid;
    logic               in_ready;
    logic [CH_W-1:0]    in_ch;
    logic [DATA_W-1:0]  in_data;
    logic [ALPHA_W-1:0] alpha;
    logic               out_valid;
    logic               out_ready;
    logic [CH_W-1:0]    out_ch;
    logic [DATA_W-1:0]  out_avg;

    modport master (
        output in_valid, in_ch, in_data, alpha, out_ready,
        input  in_ready, out_valid, out_ch, out_avg
    );

    modport slave (
        input  in_valid, in_ch, in_data, alpha, out_ready,
        output in_ready, out_valid, out_ch, out_avg
    );
endinterface

// File: rtl/ewma_update_dp.sv
// rtl/ewma_update_dp.sv - combinational avg + round(alpha*(x-avg)) update
module ewma_update_dp
    import ewma_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ALPHA_W = ALPHA_W_DEF
) (
    input  logic [DATA_W-1:0]  avg,
    input  logic [ALPHA_W-1:0] alpha,
    input  logic [DATA_W-1:0]  x,
    output logic [DATA_W-1:0]  new_avg
);
    localparam int P_W = DATA_W + ALPHA_W + 1;

    logic signed [DATA_W:0]   d;
    logic signed [P_W-1:0]    d_ext;
    logic signed [P_W-1:0]    a_ext;
    logic signed [P_W-1:0]    p;
    logic signed [P_W-1:0]    p_rnd;
    logic        [DATA_W-1:0] upd;

    assign d     = $signed({1'b0, x}) - $signed({1'b0, avg});
    assign d_ext = {{ALPHA_W{d[DATA_W]}}, d};
    assign a_ext = $signed({{(DATA_W + 1){1'b0}}, alpha});
    assign p     = d_ext * a_ext;
    assign p_rnd = p + P_W'(round_const(ALPHA_W));
    // The update magnitude never exceeds |x - avg|, so the low DATA_W bits suffice.
    assign upd     = DATA_W'(p_rnd >>> ALPHA_W);
    assign new_avg = avg + upd;

endmodule

// File: rtl/ewma_filter_mc.sv
// rtl/ewma_filter_mc.sv - time-multiplexed multi-channel EWMA filter top
module ewma_filter_mc
    import ewma_pkg::*;
#(
    parameter int              DATA_W    = 16,
    parameter int              CH        = 4,
    parameter int              CH_W      = (CH > 1) ? $clog2(CH) : 1,
    parameter int              ALPHA_W   = ALPHA_W_DEF,
    parameter logic [DATA_W-1:0] RESET_AVG = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              seed_load,
    input  logic [DATA_W-1:0] seed,
    ewma_filter_mc_if.slave   s,
    output logic              ch_err
);
    state_t             state;
    logic [DATA_W-1:0]  avg_q [CH];
    logic [CH_W-1:0]    lat_ch;
    logic [DATA_W-1:0]  lat_x;
    logic [DATA_W-1:0]  lat_avg;
    logic [ALPHA_W-1:0] lat_alpha;
    logic               out_valid_q;
    logic [CH_W-1:0]    out_ch_q;
    logic [DATA_W-1:0]  out_avg_q;
    logic [DATA_W-1:0]  new_avg;
    logic               in_ok;
    logic               lat_ok;

    assign in_ok  = int'(s.in_ch) < CH;
    assign lat_ok = int'(lat_ch) < CH;

    ewma_update_dp #(
        .DATA_W  (DATA_W),
        .ALPHA_W (ALPHA_W)
    ) u_dp (
        .avg     (lat_avg),
        .alpha   (lat_alpha),
        .x       (lat_x),
        .new_avg (new_avg)
    );

    assign s.in_ready  = (state == IDLE) && !seed_load;
    assign s.out_valid = out_valid_q;
    assign s.out_ch    = out_ch_q;
    assign s.out_avg   = out_avg_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            for (int i = 0; i < CH; i++) avg_q[i] <= RESET_AVG;
            lat_ch      <= '0;
            lat_x       <= '0;
            lat_avg     <= '0;
            lat_alpha   <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_avg_q   <= '0;
            ch_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (seed_load) begin
                        for (int i = 0; i < CH; i++) avg_q[i] <= seed;
                    end else if (s.in_valid) begin
                        lat_ch    <= s.in_ch;
                        lat_x     <= s.in_data;
                        lat_alpha <= s.alpha;
                        lat_avg   <= in_ok ? avg_q[s.in_ch] : '0;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    // Writeback lands here so a back-to-back sample sees the fresh average.
                    if (lat_ok) begin
                        avg_q[lat_ch] <= new_avg;
                        out_valid_q   <= 1'b1;
                        out_ch_q      <= lat_ch;
                        out_avg_q     <= new_avg;
                        state         <= OUT;
                    end else begin
                        ch_err <= 1'b1;
                        state  <= IDLE;
                    end
                end
                OUT: begin
                    if (s.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
